// File: rtl/spi_pixel_loader.sv
// spi_pixel_loader: oversamples an SPI mode-0 byte stream in the mainClk domain
// and unpacks every byte into four 2-bit pixels, each issued as a one-cycle
// load with a sequential frame-buffer address and a fixed minimum spacing.
module spi_pixel_loader #(
  parameter int PIXELS       = 307200,
  parameter int LOAD_SPACING = 4
) (
  input  logic        mainClk,
  input  logic        reset,
  input  logic        spiSck,
  input  logic        spiSdi,
  input  logic        spiCsN,
  output logic [18:0] addressWrite,
  output logic [1:0]  writeData,
  output logic        load,
  output logic        frameDone,
  output logic        overrun
);

  localparam int GAP_W = $clog2(LOAD_SPACING);
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(LOAD_SPACING - 1);
  localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(1);
  localparam logic [18:0] LAST_ADDR = 19'(PIXELS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    GAP  = 2'd2
  } state_t;

  logic [2:0]       sckSync_q;
  logic [2:0]       csSync_q;
  logic [1:0]       sdiSync_q;

  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bitCnt_q, bitCnt_d;
  logic [7:0]       hold_q, hold_d;
  logic             holdValid_q, holdValid_d;
  logic             overrun_q, overrun_d;
  logic [18:0]      addrCnt_q, addrCnt_d;

  state_t           state_q, state_d;
  logic [1:0]       pixIdx_q, pixIdx_d;
  logic [GAP_W-1:0] gapCnt_q, gapCnt_d;
  logic [7:0]       unpack_q, unpack_d;

  logic [18:0]      addressWrite_q;
  logic [1:0]       writeData_q;
  logic             load_q;
  logic             frameDone_q;

  logic             csFall, csRise, sckRise;
  logic [7:0]       newByte;
  logic             accept, emit;
  logic [2:0]       pixMsb;
  logic [1:0]       pixel;

  // Synchronisers plus one extra stage on sck and cs for edge detection; cs idles high
  always_ff @(posedge mainClk or posedge reset) begin
    if (reset) begin
      sckSync_q <= 3'b000;
      csSync_q  <= 3'b111;
      sdiSync_q <= 2'b00;
    end else begin
      sckSync_q <= {sckSync_q[1:0], spiSck};
      csSync_q  <= {csSync_q[1:0], spiCsN};
      sdiSync_q <= {sdiSync_q[0], spiSdi};
    end
  end

  assign csFall  = ~csSync_q[1] & csSync_q[2];
  assign csRise  = csSync_q[1] & ~csSync_q[2];
  assign sckRise = sckSync_q[1] & ~sckSync_q[2] & ~csSync_q[1];
  assign newByte = {shift_q[6:0], sdiSync_q[1]};
  assign pixMsb  = 3'd7 - {pixIdx_q, 1'b0};
  assign pixel   = unpack_q[pixMsb -: 2];

  // Unpack FSM: accept a held byte, then alternate EMIT and a gap of LOAD_SPACING-1 cycles
  always_comb begin
    state_d  = state_q;
    pixIdx_d = pixIdx_q;
    gapCnt_d = gapCnt_q;
    unpack_d = unpack_q;
    accept   = 1'b0;
    emit     = 1'b0;
    case (state_q)
      IDLE: begin
        if (holdValid_q) begin
          accept   = 1'b1;
          unpack_d = hold_q;
          pixIdx_d = 2'd0;
          state_d  = EMIT;
        end
      end
      EMIT: begin
        emit     = 1'b1;
        gapCnt_d = GAP_RELOAD;
        state_d  = GAP;
      end
      GAP: begin
        gapCnt_d = gapCnt_q - 1'b1;
        if (gapCnt_q == GAP_LAST) begin
          if (pixIdx_q != 2'd3) begin
            pixIdx_d = pixIdx_q + 1'b1;
            state_d  = EMIT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shift/hold/overrun/address bookkeeping; cs edges take priority over sck activity
  always_comb begin
    shift_d     = shift_q;
    bitCnt_d    = bitCnt_q;
    hold_d      = hold_q;
    holdValid_d = holdValid_q;
    overrun_d   = overrun_q;
    addrCnt_d   = addrCnt_q;
    if (accept) begin
      holdValid_d = 1'b0;
    end
    if (csFall) begin
      bitCnt_d  = 3'd0;
      overrun_d = 1'b0;
    end else if (csRise) begin
      bitCnt_d = 3'd0;
    end else if (sckRise) begin
      shift_d  = newByte;
      bitCnt_d = bitCnt_q + 1'b1;
      if (bitCnt_q == 3'd7) begin
        if (holdValid_q && !accept) begin
          overrun_d = 1'b1;
        end else begin
          hold_d      = newByte;
          holdValid_d = 1'b1;
        end
      end
    end
    if (emit) begin
      addrCnt_d = (addrCnt_q == LAST_ADDR) ? 19'd0 : addrCnt_q + 19'd1;
    end
    if (csFall) begin
      addrCnt_d = 19'd0;
    end
  end

  // State register for the input path and the unpack FSM
  always_ff @(posedge mainClk or posedge reset) begin
    if (reset) begin
      shift_q     <= 8'd0;
      bitCnt_q    <= 3'd0;
      hold_q      <= 8'd0;
      holdValid_q <= 1'b0;
      overrun_q   <= 1'b0;
      addrCnt_q   <= 19'd0;
      state_q     <= IDLE;
      pixIdx_q    <= 2'd0;
      gapCnt_q    <= '0;
      unpack_q    <= 8'd0;
    end else begin
      shift_q     <= shift_d;
      bitCnt_q    <= bitCnt_d;
      hold_q      <= hold_d;
      holdValid_q <= holdValid_d;
      overrun_q   <= overrun_d;
      addrCnt_q   <= addrCnt_d;
      state_q     <= state_d;
      pixIdx_q    <= pixIdx_d;
      gapCnt_q    <= gapCnt_d;
      unpack_q    <= unpack_d;
    end
  end

  // Registered pixel outputs; address and data hold their last values between loads
  always_ff @(posedge mainClk or posedge reset) begin
    if (reset) begin
      addressWrite_q <= 19'd0;
      writeData_q    <= 2'd0;
      load_q         <= 1'b0;
      frameDone_q    <= 1'b0;
    end else begin
      load_q      <= emit;
      frameDone_q <= emit && (addrCnt_q == LAST_ADDR);
      if (emit) begin
        addressWrite_q <= addrCnt_q;
        writeData_q    <= pixel;
      end
    end
  end

  assign addressWrite = addressWrite_q;
  assign writeData    = writeData_q;
  assign load         = load_q;
  assign frameDone    = frameDone_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_spi_pixel_loader.sv
// Testbench for spi_pixel_loader: instance A (16-pixel frame, spacing 4) is
// checked against a pixel scoreboard; instance B (default frame, spacing 6)
// logs its loads for spacing and overrun checks. Both share sck/sdi and have
// separate chip selects.
module tb_spi_pixel_loader;

  typedef struct {
    logic [18:0] addr;
    logic [1:0]  data;
    logic        fd;
  } pix_t;

  logic        mainClk = 1'b0;
  logic        reset;
  logic        spiSck;
  logic        spiSdi;
  logic        csA;
  logic        csB;
  logic [18:0] addrA, addrOutB;
  logic [1:0]  dataA, dataOutB;
  logic        loadA, loadB, frameDoneA, frameDoneB, overrunA, overrunB;

  int          cyc = 0;
  int          lastRiseCyc = 0;
  int          assertCount = 0;
  int          failCount = 0;
  int          modelAddr = 0;
  logic        prevLoadA = 1'b0;
  logic        prevLoadB = 1'b0;

  pix_t        expQA[$];
  int          cycA[$];
  int          cycB[$];
  logic [18:0] addrB[$];
  logic [1:0]  dataB[$];

  spi_pixel_loader #(.PIXELS(16), .LOAD_SPACING(4)) dutA (
    .mainClk(mainClk), .reset(reset), .spiSck(spiSck), .spiSdi(spiSdi), .spiCsN(csA),
    .addressWrite(addrA), .writeData(dataA), .load(loadA), .frameDone(frameDoneA),
    .overrun(overrunA)
  );

  spi_pixel_loader #(.LOAD_SPACING(6)) dutB (
    .mainClk(mainClk), .reset(reset), .spiSck(spiSck), .spiSdi(spiSdi), .spiCsN(csB),
    .addressWrite(addrOutB), .writeData(dataOutB), .load(loadB), .frameDone(frameDoneB),
    .overrun(overrunB)
  );

  // Free-running clock
  always #5 mainClk = ~mainClk;

  // Cycle counter used to time loads relative to sck edges
  always @(posedge mainClk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      $error("[TB] check %s", tag);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge mainClk);
  endtask

  task automatic spiBit(input logic b, input int half);
    spiSdi = b;
    waitCycles(half);
    spiSck = 1'b1;
    lastRiseCyc = cyc;
    waitCycles(half);
    spiSck = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] b, input int half);
    for (int i = 7; i >= 0; i--) spiBit(b[i], half);
  endtask

  task automatic expectByte(input logic [7:0] b);
    pix_t e;
    for (int i = 0; i < 4; i++) begin
      e.addr = 19'(modelAddr);
      e.data = b[7-2*i -: 2];
      e.fd   = (modelAddr == 15);
      expQA.push_back(e);
      modelAddr = (modelAddr == 15) ? 0 : modelAddr + 1;
    end
  endtask

  // Scoreboard for instance A: every load must match the next expected pixel
  always @(negedge mainClk) begin
    pix_t e;
    if (!reset) begin
      if (loadA) begin
        cycA.push_back(cyc);
        checkOutput("loadA_backToBack", 32'(prevLoadA), 32'd0);
        checkOutput("loadA_expected", 32'(expQA.size() > 0), 32'd1);
        if (expQA.size() > 0) begin
          e = expQA.pop_front();
          checkOutput("addrA", 32'(addrA), 32'(e.addr));
          checkOutput("dataA", 32'(dataA), 32'(e.data));
          checkOutput("frameDoneA", 32'(frameDoneA), 32'(e.fd));
        end
      end else begin
        checkOutput("frameDoneA_noLoad", 32'(frameDoneA), 32'd0);
      end
      prevLoadA = loadA;
    end else begin
      prevLoadA = 1'b0;
    end
  end

  // Logger for instance B loads
  always @(negedge mainClk) begin
    if (!reset) begin
      if (loadB) begin
        cycB.push_back(cyc);
        addrB.push_back(addrOutB);
        dataB.push_back(dataOutB);
        checkOutput("loadB_backToBack", 32'(prevLoadB), 32'd0);
      end
      checkOutput("frameDoneB", 32'(frameDoneB), 32'd0);
      prevLoadB = loadB;
    end else begin
      prevLoadB = 1'b0;
    end
  end

  // Directed test sequence
  initial begin
    int c;
    reset  = 1'b1;
    spiSck = 1'b0;
    spiSdi = 1'b0;
    csA    = 1'b1;
    csB    = 1'b1;
    waitCycles(4);
    checkOutput("rstAddr", 32'(addrA), 32'd0);
    checkOutput("rstData", 32'(dataA), 32'd0);
    checkOutput("rstLoad", 32'(loadA), 32'd0);
    checkOutput("rstFrameDone", 32'(frameDoneA), 32'd0);
    checkOutput("rstOverrun", 32'(overrunA), 32'd0);
    reset = 1'b0;
    waitCycles(4);

    $display("[TB] single byte 0xE4");
    csA = 1'b0;
    waitCycles(5);
    modelAddr = 0;
    cycA.delete();
    expectByte(8'hE4);
    applyStimulus(8'hE4, 4);
    c = lastRiseCyc;
    waitCycles(30);
    checkOutput("singleLoadCount", 32'(cycA.size()), 32'd4);
    for (int i = 0; i < cycA.size(); i++) begin
      checkOutput("singleLoadTime", 32'(cycA[i] - c), 32'(5 + 4 * i));
    end
    checkOutput("singleDrained", 32'(expQA.size()), 32'd0);

    $display("[TB] frame wrap");
    csA = 1'b1;
    waitCycles(5);
    csA = 1'b0;
    waitCycles(5);
    modelAddr = 0;
    for (int i = 0; i < 5; i++) begin
      expectByte(8'hFF);
      applyStimulus(8'hFF, 4);
    end
    waitCycles(30);
    checkOutput("wrapDrained", 32'(expQA.size()), 32'd0);
    checkOutput("wrapNoOverrun", 32'(overrunA), 32'd0);

    $display("[TB] partial byte");
    csA = 1'b1;
    waitCycles(5);
    csA = 1'b0;
    waitCycles(5);
    for (int i = 0; i < 5; i++) spiBit(1'b1, 4);
    csA = 1'b1;
    waitCycles(6);
    csA = 1'b0;
    waitCycles(6);
    modelAddr = 0;
    expectByte(8'h1B);
    applyStimulus(8'h1B, 4);
    waitCycles(30);
    checkOutput("partialDrained", 32'(expQA.size()), 32'd0);

    $display("[TB] async reset during emit");
    csA = 1'b1;
    waitCycles(5);
    csA = 1'b0;
    waitCycles(5);
    modelAddr = 0;
    expectByte(8'hE4);
    applyStimulus(8'hE4, 4);
    c = lastRiseCyc;
    spiBit(1'b1, 4);
    waitCycles(c + 16 - cyc);
    checkOutput("preResetAddr", 32'(addrA), 32'd2);
    reset = 1'b1;
    #1;
    checkOutput("asyncRstAddr", 32'(addrA), 32'd0);
    checkOutput("asyncRstData", 32'(dataA), 32'd0);
    checkOutput("asyncRstLoad", 32'(loadA), 32'd0);
    checkOutput("asyncRstFrameDone", 32'(frameDoneA), 32'd0);
    checkOutput("asyncRstOverrun", 32'(overrunA), 32'd0);
    checkOutput("pixelsLostToReset", 32'(expQA.size()), 32'd1);
    expQA.delete();
    csA = 1'b1;
    spiSdi = 1'b0;
    waitCycles(3);
    reset = 1'b0;
    waitCycles(20);
    csA = 1'b0;
    waitCycles(5);
    modelAddr = 0;
    expectByte(8'hE4);
    applyStimulus(8'hE4, 4);
    waitCycles(30);
    checkOutput("postResetDrained", 32'(expQA.size()), 32'd0);
    csA = 1'b1;
    waitCycles(5);

    $display("[TB] load spacing 6");
    csB = 1'b0;
    waitCycles(5);
    cycB.delete();
    addrB.delete();
    dataB.delete();
    applyStimulus(8'hE4, 4);
    c = lastRiseCyc;
    waitCycles(40);
    checkOutput("spacingLoadCount", 32'(cycB.size()), 32'd4);
    for (int i = 0; i < cycB.size(); i++) begin
      checkOutput("spacingLoadTime", 32'(cycB[i] - c), 32'(5 + 6 * i));
      checkOutput("spacingAddr", 32'(addrB[i]), 32'(i));
      checkOutput("spacingData", 32'(dataB[i]), 32'(3 - i));
    end

    $display("[TB] overrun at sck = mainClk/2");
    csB = 1'b1;
    waitCycles(5);
    csB = 1'b0;
    waitCycles(5);
    cycB.delete();
    addrB.delete();
    dataB.delete();
    for (int i = 0; i < 6; i++) applyStimulus(8'h1B, 1);
    waitCycles(200);
    checkOutput("overrunSet", 32'(overrunB), 32'd1);
    checkOutput("overrunSomeLoads", 32'(addrB.size() > 0), 32'd1);
    checkOutput("overrunSomeDropped", 32'(addrB.size() < 24), 32'd1);
    checkOutput("overrunWholeBytes", 32'(addrB.size() % 4), 32'd0);
    for (int i = 0; i < addrB.size(); i++) begin
      checkOutput("overrunAddrContiguous", 32'(addrB[i]), 32'(i));
      checkOutput("overrunData", 32'(dataB[i]), 32'(i % 4));
    end
    csB = 1'b1;
    waitCycles(8);
    checkOutput("overrunStickyAfterCsRise", 32'(overrunB), 32'd1);
    csB = 1'b0;
    waitCycles(8);
    checkOutput("overrunClearedOnCsFall", 32'(overrunB), 32'd0);
    csB = 1'b1;
    waitCycles(8);

    checkOutput("finalScoreboardEmpty", 32'(expQA.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
